// File: rtl/vproc_pkg.sv
// vproc_pkg: MMIO register map, TXSTAT layout and response-pipe entry shared by the memory bridge.
package vproc_pkg;
  localparam logic [11:0] MMIO_TXDATA = 12'h000;
  localparam logic [11:0] MMIO_TXSTAT = 12'h004;
  localparam logic [11:0] MMIO_CYCLO  = 12'h008;
  localparam logic [11:0] MMIO_CYCHI  = 12'h00C;
  localparam logic [11:0] MMIO_HALT   = 12'h010;
  localparam int TXSTAT_FULL  = 0;
  localparam int TXSTAT_EMPTY = 1;
  localparam int TXSTAT_CNT   = 8;
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;
  function automatic logic [31:0] txstat(input logic full, input logic empty, input logic [7:0] count);
    txstat = '0;
    txstat[TXSTAT_FULL] = full;
    txstat[TXSTAT_EMPTY] = empty;
    txstat[TXSTAT_CNT +: 8] = count;
  endfunction
endpackage

// File: rtl/vproc_bridge_fifo.sv
// vproc_bridge_fifo: synchronous FIFO; a push while full is accepted only alongside a pop.
module vproc_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign full_o  = r_count == CW'(DEPTH);
  assign empty_o = r_count == '0;
  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wptr] <= data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/vproc_mem_mmio_bridge.sv
// vproc_mem_mmio_bridge: routes core requests to RAM or local MMIO (TX FIFO, cycle counter, halt),
// returning MMIO responses at the RAM latency so the core sees one in-order stream.
module vproc_mem_mmio_bridge import vproc_pkg::*; #(
  parameter int          MEM_LATENCY  = 1,
  parameter logic [31:0] MMIO_BASE    = 32'hFF00_0000,
  parameter int          TXFIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_be_o,
  input  logic        ram_rvalid_i,
  input  logic        ram_err_i,
  input  logic [31:0] ram_rdata_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        halt_o,
  output logic [31:0] halt_code_o
);
  localparam int CW = $clog2(TXFIFO_DEPTH) + 1;
  logic w_is_mmio, w_mmio, w_pop, w_push, w_full, w_empty, w_err, w_lo, w_halt;
  logic [11:0] w_off;
  logic [CW-1:0] w_count;
  logic [31:0] w_rdata;
  logic [63:0] r_cycle;
  logic [31:0] r_shadow, r_halt_code;
  logic r_halt;
  resp_t [MEM_LATENCY-1:0] r_pipe;
  resp_t [MEM_LATENCY:0] w_shift;
  resp_t w_last;
  assign w_is_mmio   = addr_i[31:12] == MMIO_BASE[31:12];
  assign w_mmio      = req_i & w_is_mmio;
  assign w_off       = addr_i[11:0];
  assign ram_req_o   = req_i & ~w_is_mmio;
  assign ram_we_o    = we_i;
  assign ram_addr_o  = addr_i;
  assign ram_wdata_o = wdata_i;
  assign ram_be_o    = be_i;
  assign tx_valid_o  = ~w_empty;
  assign w_pop       = tx_valid_o & tx_ready_i;
  assign halt_o      = r_halt;
  assign halt_code_o = r_halt_code;
  // Unaligned addresses never match a register offset, so they fall into the error case.
  always_comb begin
    w_err   = !(w_off inside {MMIO_TXDATA, MMIO_TXSTAT, MMIO_CYCLO, MMIO_CYCHI, MMIO_HALT})
            | (we_i & (w_off inside {MMIO_TXSTAT, MMIO_CYCLO, MMIO_CYCHI}))
            | (we_i & (w_off == MMIO_TXDATA) & be_i[0] & w_full & ~w_pop);
    w_rdata = (we_i | w_err) ? '0
            : (w_off == MMIO_TXSTAT) ? txstat(w_full, w_empty, 8'(w_count))
            : (w_off == MMIO_CYCLO) ? r_cycle[31:0]
            : (w_off == MMIO_CYCHI) ? r_shadow : '0;
    w_push  = w_mmio & we_i & ~w_err & (w_off == MMIO_TXDATA) & be_i[0];
    w_lo    = w_mmio & ~we_i & (w_off == MMIO_CYCLO);
    w_halt  = w_mmio & we_i & (w_off == MMIO_HALT);
  end
  assign w_shift = {r_pipe, resp_t'{valid: w_mmio, err: w_err, data: w_rdata}};
  assign w_last  = w_shift[MEM_LATENCY];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_cycle     <= '0;
      r_shadow    <= '0;
      r_halt      <= 1'b0;
      r_halt_code <= '0;
      r_pipe      <= '0;
    end else begin
      r_cycle  <= r_cycle + 64'd1;
      r_shadow <= w_lo ? r_cycle[63:32] : r_shadow;
      r_halt   <= r_halt | w_halt;
      r_halt_code <= w_halt ? wdata_i : r_halt_code;
      r_pipe   <= w_shift[MEM_LATENCY-1:0];
    end
  assign rvalid_o = ram_rvalid_i | w_last.valid;
  assign err_o    = w_last.valid ? w_last.err : ram_rvalid_i & ram_err_i;
  assign rdata_o  = w_last.valid ? w_last.data : ram_rvalid_i ? ram_rdata_i : '0;
  vproc_bridge_fifo #(.WIDTH(8), .DEPTH(TXFIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (wdata_i[7:0]),
    .pop_i   (w_pop),
    .data_o  (tx_data_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );
  a_no_collision: assert property (@(posedge clk_i) disable iff (!rst_ni) !(ram_rvalid_i && w_last.valid));
endmodule

// File: tb/tb_vproc_mem_mmio_bridge.sv
// tb_vproc_mem_mmio_bridge: directed vectors against a fixed-latency RAM model, hand-computed expectations.
module tb_vproc_mem_mmio_bridge;
  localparam int ML = 3;
  localparam logic [31:0] MB = 32'hFF00_0000;
  logic clk = 0, rst_n = 0, req = 0, we = 0, tx_ready = 0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] be = '0;
  logic rvalid, err, ram_req, ram_we, ram_rvalid, ram_err, tx_valid, halt;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata, halt_code;
  logic [3:0] ram_be;
  logic [7:0] tx_data;
  logic [ML-1:0] rv_sr;
  logic [31:0] rd_sr [ML];
  logic [63:0] tb_cyc, exp_cyc;
  logic rsp_v, rsp_e, saw;
  logic [31:0] rsp_d;
  logic [7:0] q [$];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  vproc_mem_mmio_bridge #(.MEM_LATENCY(ML), .MMIO_BASE(MB), .TXFIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid), .err_o(err), .rdata_o(rdata),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_be_o(ram_be),
    .ram_rvalid_i(ram_rvalid), .ram_err_i(ram_err), .ram_rdata_i(ram_rdata),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
    .halt_o(halt), .halt_code_o(halt_code)
  );

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : a ^ 32'hA5A5_0000;
  endfunction

  // RAM model: every request answers exactly ML cycles after its request cycle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rv_sr <= '0;
      for (int i = 0; i < ML; i++) rd_sr[i] <= '0;
    end else begin
      rv_sr <= {rv_sr[ML-2:0], ram_req};
      rd_sr[0] <= (ram_req && !ram_we) ? ram_val(ram_addr) : 32'h0;
      for (int i = 1; i < ML; i++) rd_sr[i] <= rd_sr[i-1];
    end
  assign ram_rvalid = rv_sr[ML-1];
  assign ram_rdata  = rd_sr[ML-1];
  assign ram_err    = 1'b0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= '0;
    else tb_cyc <= tb_cyc + 64'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d, input logic pop);
    req = 1; we = w; addr = a; be = b; wdata = d; tx_ready = pop;
    @(posedge clk); #1;
    req = 0; we = 0; tx_ready = 0;
    repeat (ML-1) begin @(posedge clk); #1; end
    rsp_v = rvalid; rsp_e = err; rsp_d = rdata;
  endtask

  task automatic drain();
    q.delete();
    tx_ready = 1;
    for (int c = 0; c < 40 && tx_valid; c++) begin
      q.push_back(tx_data);
      @(posedge clk); #1;
    end
    tx_ready = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp", {rvalid, err, rdata}, '0);
    check("rst_tx_halt", {tx_valid, halt, halt_code}, '0);
    rst_n = 1;
    @(posedge clk); #1;
    // RAM passthrough
    req = 1; addr = 32'h100; be = 4'hF; #1;
    check("ram_req", {ram_req, ram_addr}, {1'b1, 32'h100});
    @(posedge clk); #1;
    req = 0;
    repeat (ML-2) begin @(posedge clk); #1; end
    check("ram_early", rvalid, 0);
    @(posedge clk); #1;
    check("ram_rsp", {rvalid, err, rdata}, {2'b10, 32'hDEADBEEF});
    check("ram_notx", tx_valid, 0);
    req = 1; addr = MB; #1;
    check("mmio_noram", ram_req, 0);
    req = 0;
    @(posedge clk); #1;
    // TX path
    for (int i = 0; i < 3; i++) begin
      txn(1, MB, 4'h1, 32'h41 + i, 0);
      check("tx_wr", {rsp_v, rsp_e, rsp_d}, {2'b10, 32'h0});
    end
    txn(0, MB | 32'h4, 4'hF, 0, 0);
    check("txstat3", {rsp_v, rsp_e, rsp_d}, {2'b10, 32'h0000_0300});
    drain();
    check("tx_n", q.size(), 3);
    for (int i = 0; i < 3; i++) check("tx_byte", q[i], 8'h41 + i);
    check("tx_valid0", tx_valid, 0);
    txn(1, MB, 4'h2, 32'h99, 0);
    check("tx_nobe", {rsp_v, rsp_e}, 2'b10);
    txn(0, MB | 32'h4, 4'hF, 0, 0);
    check("txstat_empty", {rsp_v, rsp_e, rsp_d}, {2'b10, 32'h0000_0002});
    // FIFO full
    for (int i = 0; i < 9; i++) begin
      txn(1, MB, 4'h1, 32'h50 + i, 0);
      check("full_wr_err", {rsp_v, rsp_e}, {1'b1, i == 8});
    end
    check("full_err_data", rsp_d, 0);
    txn(0, MB | 32'h4, 4'hF, 0, 0);
    check("txstat_full", rsp_d, 32'h0000_0801);
    drain();
    check("full_n", q.size(), 8);
    for (int i = 0; i < 8; i++) check("full_byte", q[i], 8'h50 + i);
    for (int i = 0; i < 8; i++) txn(1, MB, 4'h1, 32'h70 + i, 0);
    txn(1, MB, 4'h1, 32'h60, 1);
    check("pushpop_full", {rsp_v, rsp_e}, 2'b10);
    txn(0, MB | 32'h4, 4'hF, 0, 0);
    check("txstat_pp", rsp_d, 32'h0000_0801);
    drain();
    check("pp_n", q.size(), 8);
    check("pp_first", q[0], 8'h71);
    check("pp_last", q[7], 8'h60);
    // Counter split read
    exp_cyc = tb_cyc;
    txn(0, MB | 32'h8, 4'hF, 0, 0);
    check("cyclo", {rsp_v, rsp_e, rsp_d}, {2'b10, exp_cyc[31:0]});
    txn(0, MB | 32'hC, 4'hF, 0, 0);
    check("cychi", {rsp_v, rsp_e, rsp_d}, {2'b10, exp_cyc[63:32]});
    // Interleaved RAM / MMIO / RAM
    req = 1; be = 4'hF; addr = 32'h200;
    @(posedge clk); #1; addr = MB | 32'h4;
    @(posedge clk); #1; addr = 32'h300;
    @(posedge clk); #1; req = 0;
    check("il_0", {rvalid, err, rdata}, {2'b10, ram_val(32'h200)});
    @(posedge clk); #1;
    check("il_1", {rvalid, err, rdata}, {2'b10, 32'h0000_0002});
    @(posedge clk); #1;
    check("il_2", {rvalid, err, rdata}, {2'b10, ram_val(32'h300)});
    @(posedge clk); #1;
    check("il_idle", rvalid, 0);
    // Halt and error cases
    req = 1; we = 1; addr = MB | 32'h10; wdata = 32'h7;
    @(posedge clk); #1;
    req = 0; we = 0;
    check("halt_set", {halt, halt_code}, {1'b1, 32'h7});
    repeat (ML-1) begin @(posedge clk); #1; end
    check("halt_rsp", {rvalid, err, rdata}, {2'b10, 32'h0});
    txn(1, MB | 32'h10, 4'hF, 32'h99, 0);
    check("halt_upd", {halt, halt_code}, {1'b1, 32'h99});
    txn(0, MB | 32'h2, 4'hF, 0, 0);
    check("err_unaligned", {rsp_v, rsp_e, rsp_d}, {2'b11, 32'h0});
    txn(0, MB | 32'h100, 4'hF, 0, 0);
    check("err_offset", {rsp_v, rsp_e, rsp_d}, {2'b11, 32'h0});
    txn(1, MB | 32'h4, 4'hF, 32'h5, 0);
    check("err_ro_wr", {rsp_v, rsp_e, rsp_d}, {2'b11, 32'h0});
    txn(1, MB | 32'h8, 4'hF, 32'h5, 0);
    check("err_cyc_wr", {rsp_v, rsp_e}, 2'b11);
    txn(0, 32'h300, 4'hF, 0, 0);
    check("post_halt_ram", {rsp_v, rsp_e, rsp_d}, {2'b10, ram_val(32'h300)});
    // Reset with an MMIO read in flight
    req = 1; addr = MB | 32'h4;
    @(posedge clk); #1;
    req = 0; rst_n = 0; #1;
    check("rst_halt", {halt, halt_code}, '0);
    @(posedge clk); #1;
    rst_n = 1;
    saw = 0;
    repeat (ML+1) begin @(posedge clk); #1; saw |= rvalid; end
    check("rst_drop", saw, 0);
    exp_cyc = tb_cyc;
    txn(0, MB | 32'h8, 4'hF, 0, 0);
    check("cyclo_post_rst", {rsp_v, rsp_e, rsp_d}, {2'b10, exp_cyc[31:0]});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
